// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive/transmit blocks.
// Holds the receiver state encoding and the default frame parameters.
package serial_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, rst (async active-high), d (async in), q (synchronized out).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Oversampling 8N1 serial receiver, LSB first.
// Ports: sysclk, reset (async active-high), receive_i (serial line),
//        baud_rate_tick_i (oversample tick), data_o (last good byte),
//        valid_o / frame_error_o (one-cycle pulses), busy_o (not IDLE).
module serial_rx
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 receive_i,
    input  logic                 baud_rate_tick_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_error_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t state, state_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic load, ferr;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (sysclk),
        .rst (reset),
        .d   (receive_i),
        .q   (rx_s)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_q       <= '0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            frame_error_o <= 1'b0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_n;
            bit_cnt       <= bit_n;
            shift_q       <= shift_n;
            valid_o       <= load;
            frame_error_o <= ferr;
            if (load) begin
                data_o <= shift_q;
            end
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        load    = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (baud_rate_tick_i) begin
                    if (tick_cnt == TICK_MID) begin
                        // Mid-bit check rejects short low glitches.
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_rate_tick_i) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        shift_n = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_rate_tick_i) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n = '0;
                        if (rx_s) begin
                            load    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr    = 1'b1;
                            state_n = WAIT_HIGH;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must not look like a new start.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

endmodule
